// File: rtl/trng_collector.sv
// trng_collector: downstream stage of the ring-oscillator TRNG.
// Drives the oscillator enable, synchronizes the raw bit, applies a
// von Neumann debiaser, packs debiased bits into WIDTH-bit words and offers
// them on a valid/ready interface. A sticky repetition-count health test
// shuts the source down when the raw output sticks.
//
// Ports:
//   clk         system clock, also the TRNG sampling clock
//   reset       asynchronous active-high reset
//   enable      software enable for collector and oscillators
//   raw_bit     raw TRNG output (asynchronous to clk)
//   trng_en     oscillator enable (registered)
//   data        collected random word
//   valid       data holds an unconsumed word
//   ready       consumer takes data when valid & ready at a clk edge
//   health_fail sticky repetition-count failure flag
//
// state  | meaning
// IDLE   | collector off, partial word and health state cleared
// WARMUP | oscillators settling / synchronizer filling, samples discarded
// PAIR0  | capture first sample of a debiaser pair
// PAIR1  | compare second sample, emit first sample if the pair differs
// FAIL   | repetition-count test tripped, wait for enable to drop

module trng_collector #(
  parameter int WIDTH       = 32,
  parameter int RCT_LIMIT   = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             raw_bit,
  output logic             trng_en,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  input  logic             ready,
  output logic             health_fail
);

  localparam int CNT_W       = $clog2(WIDTH + 1);
  localparam int RUN_W       = $clog2(RCT_LIMIT + 1);
  localparam int WARM_CYCLES = SYNC_STAGES + 2;
  localparam int WARM_W      = $clog2(WARM_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WARMUP = 3'd1,
    PAIR0  = 3'd2,
    PAIR1  = 3'd3,
    FAIL   = 3'd4
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_bit;
  logic [WIDTH-1:0]       word;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   pair_b0;
  logic                   prev_bit;
  logic [RUN_W-1:0]       run_cnt;
  logic [WARM_W-1:0]      warm_cnt;

  logic [RUN_W-1:0]       run_next;
  logic                   consuming;
  logic                   rct_trip;
  logic                   emit;
  logic                   word_full;
  logic                   xfer;

  generate
    if (SYNC_STAGES == 1) begin : g_sync1
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= raw_bit;
      end
    end else begin : g_syncn
      always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], raw_bit};
      end
    end
  endgenerate

  assign s_bit = sync_q[SYNC_STAGES-1];

  always_comb begin
    consuming = (state == PAIR0) || (state == PAIR1);
    // run_cnt == 0 marks "no previous consumed sample" since warmup
    if ((run_cnt != '0) && (s_bit == prev_bit)) run_next = run_cnt + 1'b1;
    else                                         run_next = RUN_W'(1);
    rct_trip  = consuming && (run_next == RUN_W'(RCT_LIMIT));
    emit      = (state == PAIR1) && (s_bit != pair_b0);
    word_full = (bit_cnt == CNT_W'(WIDTH));
    xfer      = word_full && (!valid || ready);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      trng_en     <= 1'b0;
      data        <= '0;
      valid       <= 1'b0;
      health_fail <= 1'b0;
      word        <= '0;
      bit_cnt     <= '0;
      pair_b0     <= 1'b0;
      prev_bit    <= 1'b0;
      run_cnt     <= '0;
      warm_cnt    <= '0;
    end else begin
      trng_en <= enable & ~health_fail;

      // consumer handshake; a simultaneous transfer below overrides this
      if (valid && ready) valid <= 1'b0;

      if (!enable) begin
        state       <= IDLE;
        health_fail <= 1'b0;
        word        <= '0;
        bit_cnt     <= '0;
        pair_b0     <= 1'b0;
        prev_bit    <= 1'b0;
        run_cnt     <= '0;
        warm_cnt    <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (!health_fail) begin
              state    <= WARMUP;
              warm_cnt <= WARM_W'(WARM_CYCLES - 1);
            end
          end

          WARMUP: begin
            if (warm_cnt == '0) state <= PAIR0;
            else                warm_cnt <= warm_cnt - 1'b1;
          end

          PAIR0, PAIR1: begin
            if (rct_trip) begin
              health_fail <= 1'b1;
              state       <= FAIL;
              valid       <= 1'b0;
              word        <= '0;
              bit_cnt     <= '0;
            end else begin
              run_cnt  <= run_next;
              prev_bit <= s_bit;
              if (state == PAIR0) begin
                pair_b0 <= s_bit;
                state   <= PAIR1;
              end else begin
                state <= PAIR0;
              end
              // a full word blocks packing: bits emitted while full are lost
              if (xfer) begin
                data    <= word;
                valid   <= 1'b1;
                bit_cnt <= '0;
              end else if (emit && !word_full) begin
                word    <= {word[WIDTH-2:0], pair_b0};
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end

          FAIL: begin
            state <= FAIL;
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// tb_trng_collector: self-checking bench for trng_collector with a
// behavioural model that derives the delivered words and the health-test
// trip edge from the raw sample stream.

module tb_trng_collector;

  localparam int WIDTH       = 32;
  localparam int RCT_LIMIT   = 64;
  localparam int SYNC_STAGES = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic             raw_bit;
  logic             ready;
  logic             trng_en;
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             health_fail;

  trng_collector #(
    .WIDTH      (WIDTH),
    .RCT_LIMIT  (RCT_LIMIT),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .raw_bit    (raw_bit),
    .trng_en    (trng_en),
    .data       (data),
    .valid      (valid),
    .ready      (ready),
    .health_fail(health_fail)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  bit               r[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] got_q[$];
  bit               obs_hf[$];
  bit               obs_te[$];
  bit               obs_valid[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The three leading samples are never consumed: one edge leaves IDLE,
  // then SYNC_STAGES+2 warmup edges, and the synchronizer delays by SYNC_STAGES.
  task automatic new_stream();
    r.delete();
    repeat (3) r.push_back(1'b0);
  endtask

  task automatic push_pair(input bit a, input bit b);
    r.push_back(a);
    r.push_back(b);
  endtask

  task automatic filler(input int k);
    repeat (k) begin
      push_pair(1'b1, 1'b1);
      push_pair(1'b0, 1'b0);
    end
  endtask

  // Reference: edge e (counted from the first edge that sees enable=1)
  // consumes the sample presented SYNC_STAGES edges earlier, starting once
  // the collector has left IDLE and finished warmup. Words assume ready=1.
  task automatic model(output int fail_edge);
    int n, run, cnt, last_e;
    bit prev, first, c;
    logic [WIDTH-1:0] w;
    n = r.size(); run = 0; cnt = 0; last_e = -1;
    prev = 1'b0; first = 1'b0; w = '0; fail_edge = -1;
    exp_q.delete();
    for (int e = SYNC_STAGES + 3; e < n; e++) begin
      c = r[e - SYNC_STAGES];
      if (e > SYNC_STAGES + 3 && c == prev) run++;
      else run = 1;
      prev = c;
      if (run == RCT_LIMIT) begin
        fail_edge = e;
        break;
      end
      if (((e - SYNC_STAGES - 3) % 2) == 0) first = c;
      else if (c != first) begin
        w = (w << 1) | WIDTH'(first);
        cnt++;
        if (cnt == WIDTH) begin
          cnt = 0;
          if (e + 1 < n) begin
            exp_q.push_back(w);
            last_e = e + 1;
          end
        end
      end
    end
    if (fail_edge >= 0 && last_e == fail_edge) void'(exp_q.pop_back());
  endtask

  task automatic run_stream(input bit rdy, output int fail_edge);
    int n = r.size();
    got_q.delete(); obs_hf.delete(); obs_te.delete(); obs_valid.delete();
    fail_edge = -1;
    enable = 1'b0; ready = 1'b1; raw_bit = 1'b0;
    @(negedge clk);
    ready = rdy;
    for (int i = 0; i < n; i++) begin
      enable  = 1'b1;
      raw_bit = r[i];
      @(negedge clk);
      obs_hf.push_back(health_fail);
      obs_te.push_back(trng_en);
      obs_valid.push_back(valid);
      if (health_fail && fail_edge < 0) fail_edge = i;
      if (valid && ready) got_q.push_back(data);
    end
  endtask

  task automatic compare_words(input string tag, input int fe_obs);
    int fe_exp;
    model(fe_exp);
    check({tag, "_nwords"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check({tag, "_word"}, got_q[k], exp_q[k]);
    check({tag, "_fail_edge"}, fe_obs, fe_exp);
  endtask

  initial begin
    int fe, fe_exp, vcnt, idx;

    reset = 1'b1; enable = 1'b0; raw_bit = 1'b0; ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_trng_en", trng_en, 0);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_health", health_fail, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1,0 pairs -> all ones, valid pulses once
    new_stream(); repeat (32) push_pair(1'b1, 1'b0); filler(2);
    run_stream(1'b1, fe);
    check("ones_trng_en_lat", obs_te[0], 1);
    compare_words("ones", fe);
    check("ones_value", got_q.size() == 1 ? got_q[0] : '0, 32'hFFFF_FFFF);
    vcnt = 0;
    foreach (obs_valid[k]) if (obs_valid[k]) vcnt++;
    check("ones_valid_pulses", vcnt, 1);

    // 0,1 pairs -> all zeros
    new_stream(); repeat (32) push_pair(1'b0, 1'b1); filler(2);
    run_stream(1'b1, fe);
    compare_words("zeros", fe);
    check("zeros_value", got_q.size() == 1 ? got_q[0] : '1, 32'h0000_0000);

    // alternating differing pairs with equal pairs interleaved
    new_stream();
    repeat (16) begin
      push_pair(1'b1, 1'b0); push_pair(1'b1, 1'b1);
      push_pair(1'b0, 1'b1); push_pair(1'b0, 1'b0);
    end
    filler(2);
    run_stream(1'b1, fe);
    compare_words("alt", fe);
    check("alt_value", got_q.size() == 1 ? got_q[0] : '0, 32'hAAAA_AAAA);

    // backpressure: first word held, second completes and holds, rest dropped
    new_stream();
    repeat (32) push_pair(1'b1, 1'b0);
    repeat (32) push_pair(1'b0, 1'b1);
    repeat (32) push_pair(1'b1, 1'b0);
    filler(2);
    run_stream(1'b0, fe);
    check("bp_hold_valid", valid, 1);
    check("bp_hold_data", data, 32'hFFFF_FFFF);
    ready = 1'b1; @(negedge clk);
    check("bp_reload_data", data, 32'h0000_0000);
    check("bp_reload_valid", valid, 1);
    ready = 1'b0; @(negedge clk);
    check("bp_stable_data", data, 32'h0000_0000);
    ready = 1'b1; @(negedge clk);
    check("bp_drain_valid", valid, 0);

    // stuck-at-1 after a held word: health trips, valid and trng_en drop
    new_stream(); repeat (32) push_pair(1'b1, 1'b0);
    repeat (80) r.push_back(1'b1);
    run_stream(1'b0, fe);
    model(fe_exp);
    check("rct_edge_model", fe, fe_exp);
    check("rct_edge", fe, SYNC_STAGES + 3 + 127);
    idx = (fe < 1) ? 1 : fe;
    check("rct_hf_before", obs_hf[idx - 1], 0);
    check("rct_valid_before", obs_valid[idx - 1], 1);
    check("rct_valid_after", obs_valid[idx], 0);
    check("rct_te_same", obs_te[idx], 1);
    check("rct_te_next", obs_te[idx + 1], 0);
    enable = 1'b0; @(negedge clk);
    check("rct_clear", health_fail, 0);

    // re-enable: warmup restarts and warmup samples are not counted
    new_stream(); repeat (77) r.push_back(1'b1);
    run_stream(1'b1, fe);
    check("rct2_te", obs_te[0], 1);
    compare_words("rct2", fe);
    check("rct2_edge", fe, SYNC_STAGES + 3 + 63);

    // drop enable with 17 bits packed and a word waiting
    new_stream();
    repeat (32) push_pair(1'b1, 1'b0);
    repeat (17) push_pair(1'b0, 1'b1);
    filler(2);
    run_stream(1'b0, fe);
    enable = 1'b0; @(negedge clk);
    check("drop_valid", valid, 1);
    check("drop_data", data, 32'hFFFF_FFFF);
    ready = 1'b1; @(negedge clk);
    check("drop_consumed", valid, 0);
    new_stream(); repeat (32) push_pair(1'b1, 1'b0); filler(2);
    run_stream(1'b1, fe);
    compare_words("drop_restart", fe);
    check("drop_restart_value", got_q.size() == 1 ? got_q[0] : '0, 32'hFFFF_FFFF);

    // asynchronous reset mid-operation
    new_stream();
    repeat (32) push_pair(1'b1, 1'b0);
    repeat (10) push_pair(1'b0, 1'b1);
    filler(1);
    run_stream(1'b0, fe);
    check("mid_pre_valid", valid, 1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_trng_en", trng_en, 0);
    check("mid_rst_data", data, 0);
    check("mid_rst_valid", valid, 0);
    check("mid_rst_health", health_fail, 0);
    @(negedge clk);
    reset = 1'b0;
    new_stream(); repeat (32) push_pair(1'b1, 1'b0); filler(2);
    run_stream(1'b1, fe);
    check("mid_recover_te", obs_te[0], 1);
    compare_words("mid_recover", fe);

    // randomized raw streams
    for (int t = 0; t < 3; t++) begin
      new_stream();
      repeat (600) r.push_back(1'($urandom_range(0, 1)));
      run_stream(1'b1, fe);
      compare_words("rand", fe);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
